// File: rtl/vds_pkg.sv
// Shared constants, micro-op record and FSM state type for vector_decode_sequencer.
package vds_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_VR     = 7'b0001011;
  localparam logic [6:0] OPC_VXFER  = 7'b0101011;
  localparam logic [6:0] OPC_VMEM   = 7'b1011011;
  localparam logic [6:0] OPC_VABS   = 7'b1111011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10,
    ALU_ABS    = 4'd11
  } alu_op_e;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  // Wide enough for the largest supported register (16 elements).
  localparam int unsigned RIDX_MAX_W = 4;

  typedef struct packed {
    logic [3:0]            alu_op;
    logic [1:0]            result_source;
    logic [2:0]            width_type;
    logic [2:0]            immediate_type;
    logic [2:0]            cond_code;
    logic                  write_scalar_reg;
    logic                  write_vector_reg;
    logic                  mem_write;
    logic                  memory_transaction;
    logic                  jump;
    logic                  i_jump;
    logic                  branch;
    logic                  PC_to_ALU;
    logic                  ALU_source;
    logic                  rerouting_select;
    logic [RIDX_MAX_W-1:0] rerouting_idx;
    logic                  illegal;
    logic                  expand;
  } uop_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/vector_decode_sequencer_field_decode.sv
// Combinational opcode/f3/f7 decode of one instruction into a uop_t record.
module vds_field_decode
  import vds_pkg::*;
#(
  parameter int unsigned VLEN_ELEMS = 4
) (
  input  logic [31:0] instr,
  output uop_t        uop
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    uop = '0;
    case (opcode)
      OPC_OP: begin
        uop.alu_op           = alu_from_f3(f3, f7[5]);
        uop.write_scalar_reg = 1'b1;
      end
      OPC_OP_IMM: begin
        uop.alu_op           = alu_from_f3(f3, (f3 == 3'd5) && f7[5]);
        uop.write_scalar_reg = 1'b1;
        uop.ALU_source       = 1'b1;
        uop.immediate_type   = IMM_I;
        uop.illegal          = (f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20);
      end
      OPC_LOAD: begin
        uop.alu_op             = ALU_ADD;
        uop.result_source      = RES_MEM;
        uop.width_type         = f3;
        uop.write_scalar_reg   = 1'b1;
        uop.memory_transaction = 1'b1;
        uop.ALU_source         = 1'b1;
        uop.immediate_type     = IMM_I;
      end
      OPC_STORE: begin
        uop.alu_op             = ALU_ADD;
        uop.width_type         = f3;
        uop.mem_write          = 1'b1;
        uop.memory_transaction = 1'b1;
        uop.ALU_source         = 1'b1;
        uop.immediate_type     = IMM_S;
      end
      OPC_BRANCH: begin
        uop.alu_op         = ALU_SUB;
        uop.branch         = 1'b1;
        uop.cond_code      = f3;
        uop.immediate_type = IMM_B;
      end
      OPC_JAL: begin
        uop.alu_op           = ALU_ADD;
        uop.jump             = 1'b1;
        uop.write_scalar_reg = 1'b1;
        uop.result_source    = RES_PC4;
        uop.PC_to_ALU        = 1'b1;
        uop.ALU_source       = 1'b1;
        uop.immediate_type   = IMM_J;
      end
      OPC_JALR: begin
        uop.alu_op           = ALU_ADD;
        uop.i_jump           = 1'b1;
        uop.write_scalar_reg = 1'b1;
        uop.result_source    = RES_PC4;
        uop.ALU_source       = 1'b1;
        uop.immediate_type   = IMM_I;
      end
      OPC_LUI: begin
        uop.alu_op           = ALU_PASS_B;
        uop.write_scalar_reg = 1'b1;
        uop.ALU_source       = 1'b1;
        uop.immediate_type   = IMM_U;
      end
      OPC_AUIPC: begin
        uop.alu_op           = ALU_ADD;
        uop.write_scalar_reg = 1'b1;
        uop.PC_to_ALU        = 1'b1;
        uop.ALU_source       = 1'b1;
        uop.immediate_type   = IMM_U;
      end
      OPC_VR: begin
        uop.alu_op           = alu_from_f3(f3, f7[5]);
        uop.write_vector_reg = 1'b1;
        uop.expand           = 1'b1;
      end
      OPC_VABS: begin
        uop.alu_op           = ALU_ABS;
        uop.write_vector_reg = 1'b1;
        uop.expand           = 1'b1;
      end
      OPC_VMEM: begin
        // f7[5] selects store; loads return memory data into the vector register.
        uop.alu_op             = ALU_ADD;
        uop.width_type         = f3;
        uop.memory_transaction = 1'b1;
        uop.ALU_source         = 1'b1;
        uop.expand             = 1'b1;
        if (f7[5]) begin
          uop.mem_write      = 1'b1;
          uop.immediate_type = IMM_S;
        end else begin
          uop.write_vector_reg = 1'b1;
          uop.result_source    = RES_MEM;
          uop.immediate_type   = IMM_I;
        end
      end
      OPC_VXFER: begin
        uop.alu_op           = ALU_PASS_B;
        uop.write_scalar_reg = 1'b1;
        uop.rerouting_select = 1'b1;
        uop.rerouting_idx    = f7[RIDX_MAX_W-1:0];
        uop.illegal          = ({25'd0, f7} >= VLEN_ELEMS);
      end
      default: begin
        uop.illegal = 1'b1;
      end
    endcase

    if (uop.illegal) begin
      uop.write_scalar_reg   = 1'b0;
      uop.write_vector_reg   = 1'b0;
      uop.mem_write          = 1'b0;
      uop.memory_transaction = 1'b0;
      uop.jump               = 1'b0;
      uop.i_jump             = 1'b0;
      uop.branch             = 1'b0;
      uop.expand             = 1'b0;
    end
  end

endmodule

// File: rtl/vector_decode_sequencer.sv
// Instruction-to-micro-op sequencer; vector ops expand into VLEN_ELEMS/LANES beats.
// Optional performance counters behind macro VDS_PERF_COUNTERS_EN.
module vector_decode_sequencer
  import vds_pkg::*;
#(
  parameter int unsigned VLEN_ELEMS = 4,
  parameter int unsigned LANES      = 2,
  localparam int unsigned IDXW      = $clog2(VLEN_ELEMS),
  localparam int unsigned BEATS     = VLEN_ELEMS / LANES,
  localparam int unsigned BW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            uop_valid,
  input  logic            uop_ready,
  output logic [3:0]      alu_op,
  output logic [1:0]      result_source,
  output logic [2:0]      width_type,
  output logic [2:0]      immediate_type,
  output logic [2:0]      cond_code,
  output logic            write_scalar_reg,
  output logic            write_vector_reg,
  output logic            mem_write,
  output logic            memory_transaction,
  output logic            jump,
  output logic            i_jump,
  output logic            branch,
  output logic            PC_to_ALU,
  output logic            ALU_source,
  output logic            rerouting_select,
  output logic [IDXW-1:0] rerouting_idx,
  output logic [BW-1:0]   beat_idx,
  output logic [IDXW-1:0] lane_base,
  output logic            last_beat,
  output logic            illegal
`ifdef VDS_PERF_COUNTERS_EN
  ,
  output logic [31:0]     instr_count,
  output logic [31:0]     uop_count
`endif
);

  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [IDXW-1:0] LANE_STEP = IDXW'(LANES);

  state_e          state_q, state_d;
  uop_t            uop_q, uop_d;
  uop_t            dec;
  logic [BW-1:0]   beat_q, beat_d;
  logic [IDXW-1:0] lane_q, lane_d;
  logic            last_q, last_d;
  logic            accept;
  logic            uop_fire;

  vds_field_decode #(.VLEN_ELEMS(VLEN_ELEMS)) u_field_decode (
    .instr (instr),
    .uop   (dec)
  );

  always_comb begin
    state_d = state_q;
    uop_d   = uop_q;
    beat_d  = beat_q;
    lane_d  = lane_q;
    last_d  = last_q;

    uop_fire    = (state_q == ST_ISSUE) && uop_ready;
    instr_ready = !flush && ((state_q == ST_IDLE) || (last_q && uop_fire));
    accept      = instr_valid && instr_ready;

    if (flush) begin
      state_d = ST_IDLE;
      uop_d   = '0;
      beat_d  = '0;
      lane_d  = '0;
      last_d  = 1'b0;
    end else if (accept) begin
      // Covers both the idle load and the back-to-back load on the final beat.
      state_d = ST_ISSUE;
      uop_d   = dec;
      beat_d  = '0;
      lane_d  = '0;
      last_d  = !dec.expand || (LAST_BEAT == '0);
    end else if (uop_fire) begin
      if (last_q) begin
        state_d = ST_IDLE;
      end else begin
        beat_d = beat_q + 1'b1;
        lane_d = lane_q + LANE_STEP;
        last_d = (beat_d == LAST_BEAT) || !uop_q.expand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      uop_q   <= '0;
      beat_q  <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      beat_q  <= beat_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
    end
  end

  assign uop_valid          = (state_q == ST_ISSUE);
  assign alu_op             = uop_q.alu_op;
  assign result_source      = uop_q.result_source;
  assign width_type         = uop_q.width_type;
  assign immediate_type     = uop_q.immediate_type;
  assign cond_code          = uop_q.cond_code;
  assign write_scalar_reg   = uop_q.write_scalar_reg;
  assign write_vector_reg   = uop_q.write_vector_reg;
  assign mem_write          = uop_q.mem_write;
  assign memory_transaction = uop_q.memory_transaction;
  assign jump               = uop_q.jump;
  assign i_jump             = uop_q.i_jump;
  assign branch             = uop_q.branch;
  assign PC_to_ALU          = uop_q.PC_to_ALU;
  assign ALU_source         = uop_q.ALU_source;
  assign rerouting_select   = uop_q.rerouting_select;
  assign rerouting_idx      = uop_q.rerouting_idx[IDXW-1:0];
  assign illegal            = uop_q.illegal;
  assign beat_idx           = beat_q;
  assign lane_base          = lane_q;
  assign last_beat          = last_q;

  if (IDXW < RIDX_MAX_W) begin : g_ridx_hi
    logic unused_ridx_hi;
    assign unused_ridx_hi = |uop_q.rerouting_idx[RIDX_MAX_W-1:IDXW];
  end

`ifdef VDS_PERF_COUNTERS_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] uop_cnt_q, uop_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q + 32'(accept);
    uop_cnt_d   = uop_cnt_q + 32'(uop_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      uop_cnt_q   <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      uop_cnt_q   <= uop_cnt_d;
    end
  end

  assign instr_count = instr_cnt_q;
  assign uop_count   = uop_cnt_q;
`endif

endmodule

// File: doc/vector_decode_sequencer.md
VECTOR_DECODE_SEQUENCER -- requirements
Module: vector_decode_sequencer

Interface
REQ-001 SHALL have parameter VLEN_ELEMS, default 4, meaning elements per architectural vector register (power of 2, 2..16).
REQ-002 SHALL have parameter LANES, default 2, meaning physical vector lanes per beat (power of 2, divides VLEN_ELEMS).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, meaning synchronous pipeline flush.
REQ-006 SHALL have ports instr_valid (input, 1), instr (input, 32) and instr_ready (output, 1), meaning the instruction handshake.
REQ-007 SHALL have ports uop_valid (output, 1) and uop_ready (input, 1), meaning the micro-op handshake.
REQ-008 SHALL have micro-op outputs alu_op (4), result_source (2), width_type (3), immediate_type (3), cond_code (3), write_scalar_reg, write_vector_reg, mem_write, memory_transaction, jump, i_jump, branch, PC_to_ALU, ALU_source, rerouting_select (1 each), rerouting_idx ($clog2(VLEN_ELEMS)), beat_idx ($clog2(VLEN_ELEMS/LANES), min 1), lane_base ($clog2(VLEN_ELEMS)), last_beat (1), illegal (1), all outputs.

Function
REQ-009 SHALL decode opcode/f3/f7 with RV32I semantics plus package opcodes OPC_VR, OPC_VXFER, OPC_VMEM, OPC_VABS.
REQ-010 SHALL register all micro-op outputs; latency is 1 cycle from instruction acceptance to uop_valid.
REQ-011 SHALL implement FSM IDLE (uop_valid=0) and ISSUE (uop_valid=1).
REQ-012 SHALL assert instr_ready in IDLE, or in ISSUE when last_beat=1 and uop_ready=1; never otherwise.
REQ-013 SHALL hold every micro-op output stable while uop_valid=1 and uop_ready=0.
REQ-014 SHALL expand OPC_VR, OPC_VMEM and OPC_VABS into BEATS=VLEN_ELEMS/LANES micro-ops, with beat_idx 0..BEATS-1, lane_base=beat_idx*LANES, and last_beat=1 only on beat BEATS-1.
REQ-015 SHALL issue scalar, OPC_VXFER and illegal instructions as one micro-op with beat_idx=0 and last_beat=1.
REQ-016 SHALL advance beat_idx by 1 on each uop_ready in ISSUE while last_beat=0.
REQ-017 On uop_ready with last_beat=1: with instr_valid=1, SHALL load the next instruction and stay in ISSUE (back-to-back, no bubble); otherwise SHALL go to IDLE.
REQ-018 For OPC_VXFER, SHALL set rerouting_select=1 and rerouting_idx=f7[$clog2(VLEN_ELEMS)-1:0]; f7 >= VLEN_ELEMS SHALL set illegal=1.
REQ-019 SHALL flag illegal=1 for unknown opcodes and for OPC_OP-IMM with f3=5 and f7 not in {0x00,0x20}; illegal micro-ops SHALL force write_scalar_reg, write_vector_reg, mem_write, memory_transaction, jump, i_jump and branch to 0.
REQ-020 SHALL give flush priority over all events: the next state is IDLE and no instruction is accepted in that cycle (instr_ready=0 while flush=1).
REQ-021 SHALL treat flush mid-expansion as discarding the remaining beats.

Reset
REQ-022 SHALL, while rst_n=0, force state IDLE, uop_valid=0, beat_idx=0, and all micro-op outputs to 0.
REQ-023 SHALL assert instr_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-024 SHALL support macro VDS_PERF_COUNTERS_EN.
REQ-025 With VDS_PERF_COUNTERS_EN defined, SHALL add outputs instr_count (32) and uop_count (32), which count accepted instructions and handshaken micro-ops, wrap modulo 2^32, and clear on reset but not on flush.
REQ-026 Without VDS_PERF_COUNTERS_EN, the counter ports and logic SHALL be absent.

Structure
REQ-027 SHALL place the opcode constants, ALU_op encodings, a uop_t struct of the micro-op fields, and a state enum in package vds_pkg.
REQ-028 SHALL contain one combinational sub-module, vds_field_decode (instr in, uop_t out), instantiated once.

Verification
REQ-029 Reset then ADD x1,x2,x3 with uop_ready=1: next cycle uop_valid=1, write_scalar_reg=1, last_beat=1, illegal=0.
REQ-030 Default params, OPC_VR, uop_ready=1: two micro-ops with beat_idx 0,1 and lane_base 0,2; instr_ready=1 only on the second.
REQ-031 VLEN_ELEMS=8, LANES=2, OPC_VMEM store, uop_ready low 3 cycles on beat 1: outputs held; mem_write=1 on all 4 beats.
REQ-032 OPC_VXFER with f7=5 at VLEN_ELEMS=4: illegal=1, all write and memory enables 0; with f7=3: rerouting_idx=3.
REQ-033 flush asserted at beat 1 of 4: IDLE next cycle, no further micro-ops; the next instruction starts at beat_idx=0.
REQ-034 With VDS_PERF_COUNTERS_EN, 10 OPC_VR at default params: instr_count=10, uop_count=20.
